// File: rtl/cache_pkg.sv
// cache_pkg: shared types and constants for the direct-mapped write-back
// data cache controller (4 lines x 4 words, 64-word backing memory).
// Contents: controller state enum, geometry constants, address field
// helpers and a saturating increment used by the optional event counters.
package cache_pkg;

  localparam int WORD_W         = 32;
  localparam int ADDR_W         = 6;
  localparam int TAG_W          = 2;
  localparam int IDX_W          = 2;
  localparam int OFF_W          = 2;
  localparam int LINES          = 4;
  localparam int WORDS_PER_LINE = 4;
  localparam int STAT_W         = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COMPARE   = 2'd1,
    WRITEBACK = 2'd2,
    ALLOCATE  = 2'd3
  } state_e;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
    return a[OFF_W +: IDX_W];
  endfunction

  function automatic logic [OFF_W-1:0] addr_off(input logic [ADDR_W-1:0] a);
    return a[OFF_W-1:0];
  endfunction

  function automatic logic [ADDR_W-1:0] make_addr(input logic [TAG_W-1:0] tag,
                                                 input logic [IDX_W-1:0] idx,
                                                 input logic [OFF_W-1:0] off);
    return {tag, idx, off};
  endfunction

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == {STAT_W{1'b1}}) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/cache_controller_if.sv
// cache_controller_if: bundles the CPU load/store port, the data-array port
// and the memory beat port of the cache controller.
//   slave  : the controller's view (takes CPU requests, drives array/memory).
//   master : the surrounding system's view (core, data array, memory).
interface cache_controller_if;
  import cache_pkg::*;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [WORD_W-1:0] cpu_wdata;
  logic              cpu_done;
  logic [WORD_W-1:0] cpu_rdata;

  logic [IDX_W-1:0]  arr_index;
  logic [OFF_W-1:0]  arr_offset;
  logic              arr_we;
  logic [WORD_W-1:0] arr_wdata;
  logic [WORD_W-1:0] arr_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic [WORD_W-1:0] mem_rdata;
  logic              mem_ack;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_done, cpu_rdata,
    output arr_index, arr_offset, arr_we, arr_wdata,
    input  arr_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_done, cpu_rdata,
    input  arr_index, arr_offset, arr_we, arr_wdata,
    output arr_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );

endinterface

// File: rtl/cache_meta_array.sv
// cache_meta_array: tag/valid/dirty store for the 4 cache lines.
// Ports:
//   clock, reset          - clock, synchronous active-high clear of all entries
//   idx                   - line addressed by both read and update
//   fill_en, fill_tag     - line refill: write tag, set valid, clear dirty
//   set_dirty, clr_dirty  - dirty-bit updates for store hits / write-back end
//   rd_valid/dirty/tag    - combinational metadata of line idx
module cache_meta_array
  import cache_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic [IDX_W-1:0] idx,
  input  logic             fill_en,
  input  logic [TAG_W-1:0] fill_tag,
  input  logic             set_dirty,
  input  logic             clr_dirty,
  output logic             rd_valid,
  output logic             rd_dirty,
  output logic [TAG_W-1:0] rd_tag
);

  logic [LINES-1:0] valid_q, valid_d;
  logic [LINES-1:0] dirty_q, dirty_d;
  logic [TAG_W-1:0] tag_q [LINES];
  logic [TAG_W-1:0] tag_d [LINES];

  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    tag_d   = tag_q;
    if (fill_en) begin
      valid_d[idx] = 1'b1;
      dirty_d[idx] = 1'b0;
      tag_d[idx]   = fill_tag;
    end
    if (set_dirty) dirty_d[idx] = 1'b1;
    if (clr_dirty) dirty_d[idx] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
      tag_q   <= '{default: '0};
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
      tag_q   <= tag_d;
    end
  end

  assign rd_valid = valid_q[idx];
  assign rd_dirty = dirty_q[idx];
  assign rd_tag   = tag_q[idx];

endmodule

// File: rtl/cache_controller.sv
// cache_controller: sequencing controller for a direct-mapped write-back
// data cache. Hit service, dirty-line write-back and line allocation run as
// word-serial 4-beat memory bursts.
// Ports:
//   clock, reset  - sole clock, synchronous active-high reset
//   bus (slave)   - CPU load/store port, data-array port, memory beat port
//   stat_hits/misses/wbacks - event counters
// Optional feature: define CACHE_CTRL_STATS_EN to build saturating event
// counters; otherwise the counter outputs are tied to zero.
module cache_controller
  import cache_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  cache_controller_if.slave bus,
  output logic [STAT_W-1:0] stat_hits,
  output logic [STAT_W-1:0] stat_misses,
  output logic [STAT_W-1:0] stat_wbacks
);

  state_e            state_q, state_d;
  logic [OFF_W-1:0]  beat_q, beat_d;
  logic              cpu_done_q, cpu_done_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [OFF_W-1:0]  req_off;
  logic              meta_valid, meta_dirty;
  logic [TAG_W-1:0]  meta_tag;
  logic              fill_en, set_dirty, clr_dirty;
  logic              hit, ack_ok, last_beat, store_hit, alloc_beat;
  logic [OFF_W-1:0]  next_beat;

  // The requester holds cpu_addr stable until cpu_done, so fields are
  // decoded straight from the bus rather than latched.
  assign req_tag   = addr_tag(bus.cpu_addr);
  assign req_idx   = addr_idx(bus.cpu_addr);
  assign req_off   = addr_off(bus.cpu_addr);

  assign hit        = meta_valid && (meta_tag == req_tag);
  assign ack_ok     = bus.mem_ack && mem_req_q;
  assign last_beat  = (beat_q == OFF_W'(WORDS_PER_LINE - 1));
  assign next_beat  = beat_q + OFF_W'(1);
  assign store_hit  = (state_q == COMPARE) && hit && bus.cpu_we;
  assign alloc_beat = (state_q == ALLOCATE) && ack_ok;

  cache_meta_array u_meta (
    .clock     (clock),
    .reset     (reset),
    .idx       (req_idx),
    .fill_en   (fill_en),
    .fill_tag  (req_tag),
    .set_dirty (set_dirty),
    .clr_dirty (clr_dirty),
    .rd_valid  (meta_valid),
    .rd_dirty  (meta_dirty),
    .rd_tag    (meta_tag)
  );

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    cpu_done_d = 1'b0;
    mem_req_d  = mem_req_q;
    mem_we_d   = mem_we_q;
    mem_addr_d = mem_addr_q;
    fill_en    = 1'b0;
    set_dirty  = 1'b0;
    clr_dirty  = 1'b0;
    case (state_q)
      IDLE: begin
        // During the done cycle the finished request is still on the bus.
        if (bus.cpu_req && !cpu_done_q) state_d = COMPARE;
      end
      COMPARE: begin
        if (hit) begin
          cpu_done_d = 1'b1;
          set_dirty  = bus.cpu_we;
          state_d    = IDLE;
        end else begin
          beat_d    = '0;
          mem_req_d = 1'b1;
          if (meta_valid && meta_dirty) begin
            state_d    = WRITEBACK;
            mem_we_d   = 1'b1;
            mem_addr_d = make_addr(meta_tag, req_idx, '0);
          end else begin
            state_d    = ALLOCATE;
            mem_we_d   = 1'b0;
            mem_addr_d = make_addr(req_tag, req_idx, '0);
          end
        end
      end
      WRITEBACK: begin
        if (ack_ok) begin
          beat_d = next_beat;
          if (last_beat) begin
            clr_dirty  = 1'b1;
            state_d    = ALLOCATE;
            mem_we_d   = 1'b0;
            mem_addr_d = make_addr(req_tag, req_idx, '0);
          end else begin
            mem_addr_d = make_addr(meta_tag, req_idx, next_beat);
          end
        end
      end
      ALLOCATE: begin
        if (ack_ok) begin
          beat_d = next_beat;
          if (last_beat) begin
            fill_en    = 1'b1;
            state_d    = COMPARE;
            mem_req_d  = 1'b0;
            mem_addr_d = '0;
          end else begin
            mem_addr_d = make_addr(req_tag, req_idx, next_beat);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      cpu_done_q <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      cpu_done_q <= cpu_done_d;
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  // Array select: request word during lookup and the done cycle that
  // follows it, burst beat during write-back and allocation.
  always_comb begin
    bus.arr_index  = '0;
    bus.arr_offset = '0;
    case (state_q)
      COMPARE: begin
        bus.arr_index  = req_idx;
        bus.arr_offset = req_off;
      end
      WRITEBACK, ALLOCATE: begin
        bus.arr_index  = req_idx;
        bus.arr_offset = beat_q;
      end
      default: begin
        if (cpu_done_q) begin
          bus.arr_index  = req_idx;
          bus.arr_offset = req_off;
        end
      end
    endcase
  end

  assign bus.arr_we    = store_hit || alloc_beat;
  assign bus.arr_wdata = store_hit  ? bus.cpu_wdata :
                         alloc_beat ? bus.mem_rdata : '0;
  assign bus.mem_wdata = (state_q == WRITEBACK) ? bus.arr_rdata : '0;
  assign bus.cpu_rdata = cpu_done_q ? bus.arr_rdata : '0;
  assign bus.cpu_done  = cpu_done_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;

`ifdef CACHE_CTRL_STATS_EN
  // refill_q marks the lookup that follows a refill so that its guaranteed
  // hit is not counted a second time.
  logic              refill_q, refill_d;
  logic [STAT_W-1:0] hits_q, hits_d;
  logic [STAT_W-1:0] misses_q, misses_d;
  logic [STAT_W-1:0] wbacks_q, wbacks_d;

  always_comb begin
    refill_d = refill_q;
    hits_d   = hits_q;
    misses_d = misses_q;
    wbacks_d = wbacks_q;
    if (state_q == COMPARE) begin
      refill_d = 1'b0;
      if (hit && !refill_q) hits_d = sat_inc(hits_q);
      if (!hit) begin
        misses_d = sat_inc(misses_q);
        if (meta_valid && meta_dirty) wbacks_d = sat_inc(wbacks_q);
      end
    end
    if (fill_en) refill_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      refill_q <= 1'b0;
      hits_q   <= '0;
      misses_q <= '0;
      wbacks_q <= '0;
    end else begin
      refill_q <= refill_d;
      hits_q   <= hits_d;
      misses_q <= misses_d;
      wbacks_q <= wbacks_d;
    end
  end

  assign stat_hits   = hits_q;
  assign stat_misses = misses_q;
  assign stat_wbacks = wbacks_q;
`else
  assign stat_hits   = '0;
  assign stat_misses = '0;
  assign stat_wbacks = '0;
`endif

endmodule

// File: tb/tb_cache_controller.sv
module tb_cache_controller;
  import cache_pkg::*;

  typedef struct {
    logic        we;
    logic [5:0]  addr;
    logic [31:0] wdata;
    int          delay;
    logic [31:0] exp_rdata;
    int          exp_lat;
    int          exp_req;
    int          exp_w;
    int          exp_r;
    logic [5:0]  wb_base;
    logic [5:0]  rd_base;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_init = 1'b1;
  int   ack_delay = 0;
  int   wait_cnt = 0;
  int   wr_total = 0;
  int   rd_total = 0;
  int   log_n = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  logic [31:0] mem [64];
  logic [31:0] arr [4][4];
  logic [6:0]  log_ent [64];
  logic [15:0] stat_hits, stat_misses, stat_wbacks;

  vec_t vecs [5];

  cache_controller_if bus ();

  cache_controller dut (
    .clock       (clk),
    .reset       (rst),
    .bus         (bus.slave),
    .stat_hits   (stat_hits),
    .stat_misses (stat_misses),
    .stat_wbacks (stat_wbacks)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    if (i >= 12 && i <= 15) return 32'(88 + i);
    return 32'(1000 + i);
  endfunction

  assign bus.arr_rdata = arr[bus.arr_index][bus.arr_offset];
  assign bus.mem_rdata = mem[bus.mem_addr];
  assign bus.mem_ack   = bus.mem_req && (wait_cnt >= ack_delay);

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
    end else if (bus.mem_req && bus.mem_ack) begin
      if (bus.mem_we) begin
        mem[bus.mem_addr] <= bus.mem_wdata;
        wr_total <= wr_total + 1;
      end else begin
        rd_total <= rd_total + 1;
      end
      log_ent[log_n % 64] <= {bus.mem_we, bus.mem_addr};
      log_n <= log_n + 1;
    end
    if (bus.arr_we) arr[bus.arr_index][bus.arr_offset] <= bus.arr_wdata;
    if (rst || !bus.mem_req || bus.mem_ack) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else n_pass++;
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int done_at, req_cyc, w0, r0, l0;
    logic [31:0] rd;
    ack_delay     = v.delay;
    bus.cpu_we    = v.we;
    bus.cpu_addr  = v.addr;
    bus.cpu_wdata = v.wdata;
    bus.cpu_req   = 1'b1;
    w0 = wr_total; r0 = rd_total; l0 = log_n;
    done_at = -1; req_cyc = 0; rd = '0;
    for (int n = 0; n <= 200; n++) begin
      @(posedge clk); #1;
      if (bus.mem_req) req_cyc++;
      if (bus.cpu_done) begin
        done_at = n;
        rd = bus.cpu_rdata;
        break;
      end
    end
    bus.cpu_req = 1'b0;
    check($sformatf("v%0d_latency", id), 32'(done_at), 32'(v.exp_lat));
    if (!v.we) check($sformatf("v%0d_rdata", id), rd, v.exp_rdata);
    check($sformatf("v%0d_req_cycles", id), 32'(req_cyc), 32'(v.exp_req));
    check($sformatf("v%0d_wr_beats", id), 32'(wr_total - w0), 32'(v.exp_w));
    check($sformatf("v%0d_rd_beats", id), 32'(rd_total - r0), 32'(v.exp_r));
    for (int i = 0; i < v.exp_w; i++)
      check($sformatf("v%0d_wb_beat%0d", id, i), 32'(log_ent[(l0 + i) % 64]),
            32'({1'b1, v.wb_base + 6'(i)}));
    for (int i = 0; i < v.exp_r; i++)
      check($sformatf("v%0d_rd_beat%0d", id, i), 32'(log_ent[(l0 + v.exp_w + i) % 64]),
            32'({1'b0, v.rd_base + 6'(i)}));
    @(posedge clk); #1;
    check($sformatf("v%0d_done_pulse", id), 32'(bus.cpu_done), 32'd0);
  endtask

  initial begin : main
    int w0;
    logic [15:0] e_hits, e_misses, e_wbacks, e_misses2;
`ifdef CACHE_CTRL_STATS_EN
    e_hits = 16'd2; e_misses = 16'd3; e_wbacks = 16'd1; e_misses2 = 16'd1;
`else
    e_hits = 16'd0; e_misses = 16'd0; e_wbacks = 16'd0; e_misses2 = 16'd0;
`endif
    //          we    addr   wdata  dly rdata  lat req w  r  wb  rd
    vecs[0] = '{1'b0, 6'd13, 32'd0,  0, 32'd101,  6,  4, 0, 4, 6'd0,  6'd12};
    vecs[1] = '{1'b0, 6'd13, 32'd0,  0, 32'd101,  1,  0, 0, 0, 6'd0,  6'd0};
    vecs[2] = '{1'b1, 6'd13, 32'd55, 0, 32'd0,    1,  0, 0, 0, 6'd0,  6'd0};
    vecs[3] = '{1'b0, 6'd61, 32'd0,  0, 32'd1061, 10, 8, 4, 4, 6'd12, 6'd60};
    vecs[4] = '{1'b1, 6'd5,  32'd7,  2, 32'd0,    14, 12, 0, 4, 6'd0, 6'd4};

    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; mem_init = 1'b0;

    check("rst_state", 32'(dut.state_q), 32'(IDLE));
    check("rst_cpu_done", 32'(bus.cpu_done), 32'd0);
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_arr_we", 32'(bus.arr_we), 32'd0);
    check("rst_cpu_rdata", bus.cpu_rdata, 32'd0);
    check("rst_valid", 32'(dut.u_meta.valid_q), 32'd0);
    check("rst_dirty", 32'(dut.u_meta.dirty_q), 32'd0);
    check("rst_hits", 32'(stat_hits), 32'd0);

    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

    check("line3_valid", 32'(dut.u_meta.valid_q[3]), 32'd1);
    check("line3_tag", 32'(dut.u_meta.tag_q[3]), 32'd3);
    check("line3_dirty", 32'(dut.u_meta.dirty_q[3]), 32'd0);
    check("line1_dirty", 32'(dut.u_meta.dirty_q[1]), 32'd1);
    check("arr_1_1", arr[1][1], 32'd7);
    check("arr_1_2", arr[1][2], 32'd1006);
    check("arr_3_1", arr[3][1], 32'd1061);
    check("mem12", mem[12], 32'd100);
    check("mem13", mem[13], 32'd55);
    check("mem14", mem[14], 32'd102);
    check("mem15", mem[15], 32'd103);
    check("stat_hits", 32'(stat_hits), 32'(e_hits));
    check("stat_misses", 32'(stat_misses), 32'(e_misses));
    check("stat_wbacks", 32'(stat_wbacks), 32'(e_wbacks));

    // Dirty miss on line 1, reset while beat 2 of the write-back waits for ack.
    ack_delay = 2;
    bus.cpu_we = 1'b0; bus.cpu_addr = 6'd21; bus.cpu_wdata = '0;
    bus.cpu_req = 1'b1;
    w0 = wr_total;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk); #1;
      if (wr_total - w0 >= 2) break;
    end
    check("mid_wb_beats", 32'(wr_total - w0), 32'd2);
    check("mid_wb_beat", 32'(dut.beat_q), 32'd2);
    rst = 1'b1;
    @(posedge clk); #1;
    check("post_rst_state", 32'(dut.state_q), 32'(IDLE));
    check("post_rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("post_rst_valid", 32'(dut.u_meta.valid_q), 32'd0);
    check("post_rst_dirty", 32'(dut.u_meta.dirty_q), 32'd0);
    check("post_rst_beat", 32'(dut.beat_q), 32'd0);
    check("post_rst_no_wb", 32'(wr_total - w0), 32'd2);
    rst = 1'b0;
    bus.cpu_req = 1'b0;
    ack_delay = 0;
    @(posedge clk); #1;

    run_vec('{1'b0, 6'd13, 32'd0, 0, 32'd55, 6, 4, 0, 4, 6'd0, 6'd12}, 5);
    check("after_rst_hits", 32'(stat_hits), 32'd0);
    check("after_rst_misses", 32'(stat_misses), 32'(e_misses2));
    check("after_rst_wbacks", 32'(stat_wbacks), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cache_controller.md
# cache_controller

Sequencing controller for the direct-mapped, write-back data cache between the CPU and the 64-word data memory. Owns the tag, valid and dirty metadata for the 4 lines, drives the data-array port, and runs hit service, dirty-line write-back and line allocation as word-serial memory bursts. Sits in `top` between the core's load/store port, the cache data array and the data memory.

## Interface
- `WORD_W`, 32: data word width.
- `ADDR_W`, 6: word address width. Fields: tag [5:4], index [3:2], offset [1:0].
- `clock` in 1: sole clock. All state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `cpu_req` in 1: request valid. Held with `cpu_we`, `cpu_addr` and `cpu_wdata` stable until `cpu_done`.
- `cpu_we` in 1: 1 = store, 0 = load.
- `cpu_addr` in ADDR_W: word address.
- `cpu_wdata` in WORD_W: store data.
- `cpu_done` out 1: one-cycle completion pulse.
- `cpu_rdata` out WORD_W: load data, valid while `cpu_done`=1.
- `arr_index` out 2, `arr_offset` out 2: data-array line and word select.
- `arr_we` out 1, `arr_wdata` out WORD_W: data-array write port.
- `arr_rdata` in WORD_W: data-array combinational read data.
- `mem_req` out 1, `mem_we` out 1, `mem_addr` out ADDR_W, `mem_wdata` out WORD_W: memory beat request.
- `mem_rdata` in WORD_W, `mem_ack` in 1: beat completion. May be high in the same cycle as `mem_req`.
- `stat_hits`, `stat_misses`, `stat_wbacks` out 16: event counters (see Configuration).

## Operation
- States:
  - IDLE: if `cpu_req`=1, latch nothing and go to COMPARE.
  - COMPARE: lookup. Hit = `valid[idx]` && tag match.
  - WRITEBACK: dirty victim is written out.
  - ALLOCATE: line is filled from memory.
- COMPARE on hit:
  - Load: `cpu_rdata`=`arr_rdata` at `{idx,off}`.
  - Store: `arr_we`=1 and set `dirty[idx]`.
  - `cpu_done`=1, then go to IDLE.
- COMPARE on miss: go to WRITEBACK if the line is valid and dirty, otherwise to ALLOCATE.
- WRITEBACK:
  - Each beat: `mem_we`=1, `mem_addr`={old tag, idx, beat}, `mem_wdata`=`arr_rdata` at `{idx,beat}`.
  - Beat counter advances on `mem_ack`. After beat 3 is acked: clear dirty, go to ALLOCATE.
- ALLOCATE:
  - Each beat: `mem_we`=0, `mem_addr`={new tag, idx, beat}.
  - On `mem_ack`: `arr_we`=1, `arr_wdata`=`mem_rdata`, `arr_offset`=beat.
  - After beat 3 is acked: write the tag, set valid, go to COMPARE. That COMPARE is always a hit.
- Beat counter: 2 bits, starts at 0 on phase entry, wraps 3→0 at phase end.
- `mem_req` stays high throughout WRITEBACK and ALLOCATE, including beats with no ack.
- `cpu_req` low in COMPARE is a protocol violation. The controller completes the operation regardless.
- A store miss allocates first, then writes in the final COMPARE (write-allocate).

## Timing
- Reset values:
  - State IDLE; all valid and dirty bits 0; beat counter 0.
  - `cpu_done`, `mem_req`, `mem_we`, `arr_we` = 0.
  - `cpu_rdata`, `mem_wdata`, `arr_wdata` = 0.
  - `arr_index`, `arr_offset`, `mem_addr` = 0.
  - Counters 0.
- Hit: request seen in IDLE at edge k; `cpu_done` high during cycle k+1.
- Clean miss with single-cycle acks: done at cycle k+6. Dirty miss: done at cycle k+10.
- Back-to-back: IDLE re-samples `cpu_req` the cycle after `cpu_done`. The requester must present a new request or drop `cpu_req` there.
- Reset mid-burst:
  - Next edge gives IDLE and all metadata cleared.
  - Dirty data is discarded without write-back.
  - `mem_req` is low in the cycle after the reset edge.
- Outputs are registered except `cpu_rdata`, `arr_*` and `mem_wdata`, which decode combinationally from state, beat and latched fields.

## Configuration
- `CACHE_CTRL_STATS_EN` defined:
  - `stat_hits` increments on first-pass COMPARE hits.
  - `stat_misses` increments on each miss.
  - `stat_wbacks` increments on each WRITEBACK entry.
  - All three saturate at 16'hFFFF and clear on reset.
- Undefined: the three counters are tied to 0 and no counter logic is built.

## Structure
- Shared package `cache_pkg`:
  - state enum (IDLE, COMPARE, WRITEBACK, ALLOCATE);
  - `TAG_W`=2, `IDX_W`=2, `OFF_W`=2, `LINES`=4, `WORDS_PER_LINE`=4;
  - address field-extract helpers.
- One sub-module `cache_meta_array`: the 4-entry tag/valid/dirty store with synchronous clear on reset.

## Test plan
- Cold load at 13 with mem[12..15]=100..103 → 4 read beats at addresses 12..15; `cpu_done` at k+6 with `cpu_rdata`=101; line 3 valid, tag 2'b00.
- Repeat load at 13 → hit; `cpu_done` at k+1; no `mem_req`.
- Store 55 at 13 → hit; `dirty[3]`=1. Then load at 61 → 4 write beats to 12..15 carrying 100,55,102,103, then 4 read beats at 60..63; `dirty[3]`=0, tag 2'b11.
- Store miss at 5 (data 7) with `mem_ack` delayed 2 cycles per beat → `mem_req` held throughout; block[1][1]=7, `dirty[1]`=1.
- Reset asserted during beat 2 of a write-back → next cycle: IDLE, `mem_req`=0, all valid/dirty 0; a following load at 13 misses.
- With `CACHE_CTRL_STATS_EN`, run the sequence above → hits=2, misses=3, wbacks=1. Without the macro → all counters 0.
